// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM state encoding and counter sizing.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: ceil(log2(slices)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational W-bit ripple-carry adder built from a chain of full-adder cells.
module digit_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];

endmodule

// File: rtl/multicycle_adder.sv
// Digit-serial adder/subtractor: adds one DIGIT-wide slice per cycle, LSB first,
// and presents the result with carry, signed overflow and zero flags.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] s,
  output logic            co,
  output logic            ovf,
  output logic            zero
);

  localparam int unsigned SLICES = BITS / DIGIT;
  localparam int unsigned CW     = cnt_width(SLICES);
  localparam int unsigned IW     = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  state_t          state, state_d;
  logic [BITS-1:0] a_q, b_q, a_d, b_d, s_d, s_new;
  logic [CW-1:0]   cnt, cnt_d;
  logic            carry, carry_d;
  logic            co_d, ovf_d, zero_d;
  logic            in_ready_d, out_valid_d;
  logic [IW-1:0]   base;
  logic [DIGIT-1:0] slice_s;
  logic            slice_co;

  // Bit offset of the slice currently being added.
  assign base = IW'(32'(cnt) * DIGIT);

  digit_adder #(.W(DIGIT)) u_digit (
    .a  (a_q[base +: DIGIT]),
    .b  (b_q[base +: DIGIT]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Result with the current slice merged in; flags are taken from this on the last slice.
  always_comb begin
    s_new = s;
    s_new[base +: DIGIT] = slice_s;
  end

  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry;
    cnt_d   = cnt;
    s_d     = s;
    co_d    = co;
    ovf_d   = ovf;
    zero_d  = zero;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {BITS{sub}};
          carry_d = ci ^ sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_new;
        carry_d = slice_co;
        if (cnt == LAST) begin
          state_d = DONE;
          co_d    = slice_co;
          ovf_d   = (a_q[BITS-1] == b_q[BITS-1]) && (s_new[BITS-1] != a_q[BITS-1]);
          zero_d  = (s_new == '0);
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry     <= carry_d;
      cnt       <= cnt_d;
      s         <= s_d;
      co        <= co_d;
      ovf       <= ovf_d;
      zero      <= zero_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed and randomised checks of multicycle_adder (8/4 instance plus a 32/32 instance).
module tb_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
  logic [7:0] a, b, s;

  logic        v32, rdy32, ci32, sub32, ov32, ordy32, co32, ovf32, zero32;
  logic [31:0] a32, b32, s32;

  int total = 0;
  int bad   = 0;

  multicycle_adder #(.BITS(8), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .zero(zero)
  );

  multicycle_adder #(.BITS(32), .DIGIT(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
    .a(a32), .b(b32), .ci(ci32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32),
    .s(s32), .co(co32), .ovf(ovf32), .zero(zero32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: {co, ovf, zero, s} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic mci, input logic msub);
    int r_u, r_s;
    logic [7:0] rs;
    logic rco, rovf;
    if (!msub) begin
      r_u = int'(ma) + int'(mb) + int'(mci);
      r_s = int'($signed(ma)) + int'($signed(mb)) + int'(mci);
      rco = (r_u > 255);
    end else begin
      r_u = int'(ma) - int'(mb) - int'(mci);
      r_s = int'($signed(ma)) - int'($signed(mb)) - int'(mci);
      rco = (r_u >= 0);
    end
    rs   = r_u[7:0];
    rovf = (r_s > 127) || (r_s < -128);
    return {rco, rovf, (rs == 8'h00), rs};
  endfunction

  // One full transaction; latency counts the accept cycle plus the RUN cycles.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input logic tsub, input int stall, input logic [10:0] exp);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_wait", 64'(guard < 20), 64'(1));
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(3));
    check("result", 64'({co, ovf, zero, s}), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      a = 8'h3C;
      @(posedge clk); #1;
      check("hold", 64'({in_ready, out_valid, co, ovf, zero, s}), 64'({2'b01, exp}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic rci, rsub;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b0;
    #12;
    check("reset8", 64'({in_ready, out_valid, co, ovf, zero, s}), 64'({2'b10, 3'b000, 8'h00}));
    check("reset32", 64'({rdy32, ov32, co32, ovf32, zero32, s32}), 64'({2'b10, 3'b000, 32'h0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, {1'b1, 1'b0, 1'b1, 8'h00});
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, {1'b1, 1'b1, 1'b0, 8'h7F});
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, {1'b0, 1'b0, 1'b0, 8'hFE});
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, {1'b0, 1'b1, 1'b0, 8'h80});
    run_op(8'h05, 8'h05, 1'b1, 1'b1, 0, {1'b0, 1'b0, 1'b0, 8'hFF});
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 5, {1'b1, 1'b0, 1'b1, 8'h00});

    // Reset in the second RUN cycle, then a clean operation.
    a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("run_busy", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({in_ready, out_valid, co, ovf, zero, s}), 64'({2'b10, 3'b000, 8'h00}));
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, {1'b0, 1'b0, 1'b0, 8'h46});

    // Single-slice configuration: one RUN cycle.
    a32 = 32'h7FFF_FFFF; b32 = 32'h1; ci32 = 1'b0; sub32 = 1'b0; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; a32 = 32'hDEAD_BEEF;
    lat = 1;
    while (!ov32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat32", 64'(lat), 64'(2));
    check("result32", 64'({co32, ovf32, zero32, s32}), 64'({1'b0, 1'b1, 1'b0, 32'h8000_0000}));
    ordy32 = 1'b1;
    @(posedge clk); #1;
    ordy32 = 1'b0;
    check("release32", 64'({rdy32, ov32}), 64'(2'b10));

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom); rsub = 1'($urandom);
      run_op(ra, rb, rci, rsub, int'($urandom_range(0, 3)), model(ra, rb, rci, rsub));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
